multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Controller that time-shares one WIDTH-bit ripple adder slice (the team's existing four-bit full adder) to add operands WORDS slices wide.
- Operates serially, one slice per clock, least-significant slice first, with carry registered between slices.
- Accepts an operand pair through a valid/ready handshake, drives the external adder's a/b/c_in ports, and collects its sum/c_out.
- Presents the full-width result on a held valid/ready output.

Parameters:
- WIDTH, 4, bit width of the shared adder slice (must match the adder instance).
- WORDS, 4, number of slices per operand; total operand width N = WIDTH*WORDS; WORDS >= 1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept operands
- a  input  N  operand A
- b  input  N  operand B
- c_in  input  1  carry into slice 0
- add_a  output  WIDTH  to shared adder a
- add_b  output  WIDTH  to shared adder b
- add_cin  output  1  to shared adder c_in
- add_sum  input  WIDTH  from shared adder sum
- add_cout  input  1  from shared adder c_out
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result
- sum  output  N  full-width result
- c_out  output  1  carry out of top slice
- busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, res_valid=0, sum=0, c_out=0, busy=0; internal slice index, carry and operand registers = 0.
- A reset asserted in any state, including mid-RUN or DONE, aborts the operation. The partial result is discarded and the block returns to IDLE the next cycle.
- State machine, three states:
  - IDLE: in_ready=1. On in_valid&&in_ready, register a, b and c_in, clear sum, set idx=0, go to RUN.
  - RUN: one slice per cycle.
    - add_a = a_reg[idx*WIDTH +: WIDTH], add_b likewise, add_cin = carry_reg (c_in for idx 0).
    - At the clock edge: sum[idx*WIDTH +: WIDTH] <= add_sum, carry_reg <= add_cout, idx <= idx+1.
    - When idx==WORDS-1: c_out <= add_cout and go to DONE.
  - DONE: res_valid=1. sum and c_out are held stable. On res_ready, go to IDLE (res_valid drops the next cycle).
- The adder is purely combinational and external. The block depends on add_sum/add_cout settling within the cycle.
- add_a, add_b and add_cin are driven 0 outside RUN.
- Latency: handshake accepted at edge E; res_valid is high from edge E+WORDS onward (4 cycles at default).
- Throughput: one operation per WORDS+2 cycles minimum. in_ready is 0 in RUN and DONE, so in_valid there is ignored with no effect on operands.
- Result is an exact (N+1)-bit sum {c_out,sum} = a + b + c_in; wrap-around is mod 2^N with the carry reported in c_out.
- WORDS==1: RUN lasts exactly one cycle.
- Simultaneous res_ready and in_valid in DONE: the result is consumed; new operands are accepted no earlier than the following IDLE cycle.
- busy = (state != IDLE).

Test Plan:
- 0x1234 + 0x4321, c_in=0 -> after 4 cycles res_valid=1, sum=0x5555, c_out=0. Each RUN cycle add_a/add_b show slices 4/1, 3/2, 2/3, 1/4.
- 0xFFFF + 0x0001, c_in=0 -> sum=0x0000, c_out=1. add_cin=1 in RUN cycles 2-4 (carry ripples across all slices).
- 0x0F0F + 0x00F1, c_in=1 -> sum=0x1001, c_out=0. 0xFFFF + 0xFFFF, c_in=1 -> sum=0xFFFF, c_out=1.
- Backpressure: hold res_ready=0 for 3 cycles in DONE -> sum/c_out/res_valid stable. Toggle in_valid with other operands during RUN/DONE -> in_ready=0 and the result is unchanged.
- Reset in 2nd RUN cycle -> next cycle state IDLE, in_ready=1, res_valid=0, sum=0, c_out=0, add_* = 0. A following 0x0001+0x0001 yields 0x0002.
- Back-to-back: keep in_valid=1 and res_ready=1 continuously -> operations complete every WORDS+2 cycles with correct results and no dropped or duplicated transaction.

Source files
------------

// File: rtl/multiword_add_sequencer.sv
// Serial multi-word adder: time-shares one external WIDTH-bit adder slice,
// one slice per clock, LSB slice first, with the carry registered between slices.
module multiword_add_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*WORDS-1:0]   a,
    input  logic [WIDTH*WORDS-1:0]   b,
    input  logic                     c_in,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_cout,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH*WORDS-1:0]   sum,
    output logic                     c_out,
    output logic                     busy
);

    localparam int unsigned N    = WIDTH * WORDS;
    localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic            carry_reg;
    logic [IDXW-1:0] idx;
    logic            accept;

    assign accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (idx == LAST_IDX) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; the adder ports are quiet outside RUN
    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            RUN: begin
                busy    = 1'b1;
                add_a   = a_reg[32'(idx) * WIDTH +: WIDTH];
                add_b   = b_reg[32'(idx) * WIDTH +: WIDTH];
                add_cin = carry_reg;
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture and per-slice result collection
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= c_in;
                        idx       <= '0;
                        sum       <= '0;
                    end
                end
                RUN: begin
                    sum[32'(idx) * WIDTH +: WIDTH] <= add_sum;
                    carry_reg <= add_cout;
                    idx       <= idx + IDXW'(1);
                    if (idx == LAST_IDX) begin
                        c_out <= add_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer against an arithmetic
// reference (a + b + c_in) with a behavioural model of the shared adder slice.
module tb_multiword_add_sequencer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned WORDS = 4;
    localparam int unsigned N     = WIDTH * WORDS;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             c_in;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             res_valid;
    logic             res_ready;
    logic [N-1:0]     sum;
    logic             c_out;
    logic             busy;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // The shared combinational adder slice
    assign {add_cout, add_sum} = (WIDTH+1)'(add_a) + (WIDTH+1)'(add_b) + (WIDTH+1)'(add_cin);

    multiword_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .sum(sum), .c_out(c_out), .busy(busy)
    );

    function automatic logic [N:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
        return (N+1)'(x) + (N+1)'(y) + (N+1)'(ci);
    endfunction

    function automatic logic [WIDTH-1:0] slice_of(input logic [N-1:0] v, input int k);
        return WIDTH'(v >> (k * WIDTH));
    endfunction

    // Carry entering slice k: carry out of the low k*WIDTH bits of the sum
    function automatic logic carry_into(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci, input int k);
        longint unsigned m;
        longint unsigned s;
        if (k == 0) return ci;
        m = (64'd1 << (k * WIDTH)) - 64'd1;
        s = (longint'(x) & m) + (longint'(y) & m) + longint'(ci);
        return s[k * WIDTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
        tick(); tick();
        rst = 1'b0;
        vectors++;
        if ({in_ready, res_valid, busy} !== 3'b100 || sum !== '0 || c_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: ready/valid/busy=%b sum=%h c_out=%b expected 100 0000 0", {in_ready, res_valid, busy}, sum, c_out);
        end
        vectors++;
        if ({add_a, add_b, add_cin} !== '0) begin
            miscompares++;
            $display("FAIL reset_adder_ports: add_a/b/cin=%h/%h/%b expected 0/0/0", add_a, add_b, add_cin);
        end
    endtask

    // One full transaction with cycle-exact checks; noise toggles in_valid with junk operands
    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic ci,
                          input int hold, input bit noise, input string name);
        logic [N:0] exp;
        exp = ref_add(av, bv, ci);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_before: in_ready=%b busy=%b expected 1 0", name, in_ready, busy);
        end
        a = av; b = bv; c_in = ci; in_valid = 1'b1; res_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < int'(WORDS); k++) begin
            if (noise) begin
                in_valid = 1'($urandom); a = N'($urandom); b = N'($urandom); c_in = 1'($urandom);
            end
            vectors++;
            if ({add_a, add_b, add_cin} !== {slice_of(av, k), slice_of(bv, k), carry_into(av, bv, ci, k)}) begin
                miscompares++;
                $display("FAIL %s slice%0d: add_a/b/cin=%h/%h/%b expected %h/%h/%b", name, k, add_a, add_b, add_cin,
                         slice_of(av, k), slice_of(bv, k), carry_into(av, bv, ci, k));
            end
            vectors++;
            if ({busy, in_ready, res_valid} !== 3'b100) begin
                miscompares++;
                $display("FAIL %s run%0d_flags: busy/ready/valid=%b expected 100", name, k, {busy, in_ready, res_valid});
            end
            tick();
        end
        for (int h = 0; h <= hold; h++) begin
            vectors++;
            if ({res_valid, in_ready, busy} !== 3'b101 || {c_out, sum} !== exp) begin
                miscompares++;
                $display("FAIL %s done%0d: valid/ready/busy=%b c_out/sum=%b/%h expected 101 %b/%h", name, h,
                         {res_valid, in_ready, busy}, c_out, sum, exp[N], exp[N-1:0]);
            end
            vectors++;
            if ({add_a, add_b, add_cin} !== '0) begin
                miscompares++;
                $display("FAIL %s done%0d_adder_ports: %h/%h/%b expected 0/0/0", name, h, add_a, add_b, add_cin);
            end
            if (noise) begin
                in_valid = 1'($urandom); a = N'($urandom); b = N'($urandom); c_in = 1'($urandom);
            end
            if (h == hold) begin
                res_ready = 1'b1;
                if (noise) in_valid = 1'b1;
            end
            tick();
        end
        res_ready = 1'b0; in_valid = 1'b0;
        vectors++;
        if ({res_valid, in_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL %s after_consume: valid/ready/busy=%b expected 010", name, {res_valid, in_ready, busy});
        end
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, "add_1234_4321");
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "carry_ripple");
        run_op(16'h0F0F, 16'h00F1, 1'b1, 0, 1'b0, "cin_0f0f_00f1");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0, "max_operands");
    endtask

    task automatic test_backpressure();
        run_op(16'hA5C3, 16'h7E19, 1'b1, 3, 1'b1, "backpressure");
    endtask

    task automatic test_reset_mid_run();
        a = 16'h8888; b = 16'h9999; c_in = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({in_ready, res_valid, busy} !== 3'b100 || sum !== '0 || c_out !== 1'b0 || {add_a, add_b, add_cin} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_run: ready/valid/busy=%b sum=%h c_out=%b add=%h/%h/%b expected 100 0000 0 0/0/0",
                     {in_ready, res_valid, busy}, sum, c_out, add_a, add_b, add_cin);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, "after_reset_1_plus_1");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [N:0] exp_q[$];
        logic [N:0] exp;
        int ops, sent, got, cyc, last_done;
        bit acc;
        ops = 8; sent = 0; got = 0; cyc = 0; last_done = -1;
        a = N'($urandom); b = N'($urandom); c_in = 1'($urandom);
        in_valid = 1'b1; res_ready = 1'b1;
        while (got < ops && cyc < 400) begin
            if (res_valid === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                vectors++;
                if ({c_out, sum} !== exp) begin
                    miscompares++;
                    $display("FAIL b2b_result%0d: c_out/sum=%b/%h expected %b/%h", got, c_out, sum, exp[N], exp[N-1:0]);
                end
                if (last_done >= 0) begin
                    vectors++;
                    if (cyc - last_done != int'(WORDS) + 2) begin
                        miscompares++;
                        $display("FAIL b2b_interval%0d: %0d cycles expected %0d", got, cyc - last_done, WORDS + 2);
                    end
                end
                last_done = cyc;
                got++;
            end
            acc = (in_ready === 1'b1) && in_valid;
            if (acc) begin
                exp_q.push_back(ref_add(a, b, c_in));
                sent++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (sent < ops) begin
                    a = N'($urandom); b = N'($urandom); c_in = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        vectors++;
        if (got != ops || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count: results=%0d pending=%0d expected %0d and 0", got, exp_q.size(), ops);
        end
        in_valid = 1'b0; res_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
